countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Loadable down-counter / interval timer. Counts a programmed value down to
//  zero one step per clk cycle and pulses done on expiry. Optional auto-reload
//  for periodic ticks. Sits beside the up-counters in the lab datapath and
//  drives timeouts, display refresh and blink strobes.
// PARAMETERS
//  WIDTH  4  counter / load value width in bits
// PORTS
//  clk          in   1      rising-edge clock, single clock domain
//  reset        in   1      asynchronous, active-low reset (0 = reset)
//  load         in   1      load load_val into count and reload register
//  load_val     in   WIDTH  value taken on load
//  start        in   1      begin counting; accepted only in IDLE
//  stop         in   1      abort to IDLE; count holds its current value
//  pause        in   1      level: hold count while high (RUN <-> PAUSED)
//  auto_reload  in   1      level, sampled at the expiry edge
//  count        out  WIDTH  current count value (registered)
//  busy         out  1      1 in RUN or PAUSED
//  done         out  1      one-cycle expiry pulse (registered)
// BEHAVIOUR
//  - Reset (reset=0, async): count=0, reload_reg=0, state=IDLE, busy=0, done=0.
//  - States: IDLE, RUN, PAUSED. busy = (state!=IDLE). done defaults to 0 every cycle.
//  - Per-edge priority: load > stop > start/pause > decrement.
//  - load (any state): count<=load_val, reload_reg<=load_val, state<=IDLE,
//    done<=0. Any start/stop/pause in the same cycle is ignored.
//  - stop in RUN/PAUSED: state<=IDLE, count holds, no done. No effect in IDLE.
//  - IDLE + start: if count!=0, state<=RUN and count is unchanged on that edge.
//    If count==0, done<=1 and state stays IDLE.
//  - start in RUN/PAUSED is ignored; it is not queued.
//  - RUN, pause=0, count>1: count<=count-1.
//  - RUN, pause=0, count==1 (expiry edge): done<=1.
//    If auto_reload=1: count<=reload_reg, state stays RUN.
//    If auto_reload=0: count<=0, state<=IDLE.
//  - Latency: done asserts N edges after the edge that accepted start (N = loaded
//    value). With auto-reload, done repeats every N cycles and count never shows 0.
//  - RUN + pause=1: state<=PAUSED, count holds. pause wins over an expiry on the
//    same edge.
//  - PAUSED + pause=0: state<=RUN, count holds on that edge; decrement resumes
//    on the next edge.
//  - No underflow: count never decrements below 0 and never wraps to all-ones.
//  - Arithmetic is unsigned WIDTH-bit. Max period = 2**WIDTH-1 cycles.
//  - Reset asserted mid-count aborts immediately to the reset values above; no
//    done pulse is produced.
// TESTING
//  1 reset low mid-RUN (count=3) -> count=0, busy=0, done=0 asynchronously;
//    stays IDLE after release.
//  2 load 5, start -> busy=1, count 5,4,3,2,1,0 on successive edges; done=1
//    for exactly 1 cycle with count=0; busy=0 afterwards.
//  3 load 3, auto_reload=1, start -> count 2,1,3,2,1,3...; done pulses every
//    3 cycles; stop -> IDLE, count frozen.
//  4 load 6, start, pause high for 4 cycles at count=4 -> count holds 4, busy=1;
//    release -> 4 for one more edge, then 3,2,1,0; done 4+1 cycles later than
//    the unpaused case.
//  5 load 0, start -> done=1 one cycle, busy never set. Then start in RUN
//    (load 4) is ignored, and load 9 during RUN -> count=9, IDLE, no done.
//  6 WIDTH=4, load 15, start -> done after exactly 15 edges; count never
//    shows 4'hF after the first decrement.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause, stop, auto-reload and a one-cycle expiry pulse
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
  logic done_q, done_d;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else if (stop && state_q != IDLE) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d = (count_q != '0) ? RUN : IDLE;
        done_d  = (count_q == '0);
      end
    end else if (state_q == PAUSED) begin
      state_d = pause ? PAUSED : RUN;
    end else if (pause) begin
      state_d = PAUSED;
    end else if (count_q > WIDTH'(1)) begin
      count_d = count_q - WIDTH'(1);
    end else if (count_q == WIDTH'(1)) begin
      done_d  = 1'b1;
      count_d = auto_reload ? reload_q : '0;
      state_d = auto_reload ? RUN : IDLE;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end
  assign count = count_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed-vector bench for countdown_timer with immediate assertions
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count;
  logic       busy, done;
  int vectors = 0;
  int miss = 0;
  int n;
  countdown_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .pause(pause), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    load_val = v;
    tick;
    load = 1'b0;
  endtask
  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    // basic one-shot count of 5
    do_load(4'd5);
    chk("t2_load_count", count, 5);
    chk("t2_load_busy", busy, 0);
    do_start;
    chk("t2_start_busy", busy, 1);
    chk("t2_start_count", count, 5);
    for (int i = 4; i >= 1; i--) begin
      tick;
      chk("t2_count", count, i);
      chk("t2_done_low", done, 0);
    end
    tick;
    chk("t2_exp_count", count, 0);
    chk("t2_exp_done", done, 1);
    chk("t2_exp_busy", busy, 0);
    tick;
    chk("t2_done_once", done, 0);
    chk("t2_idle", busy, 0);
    // periodic auto-reload of 3, then stop
    auto_reload = 1'b1;
    do_load(4'd3);
    do_start;
    chk("t3_start_count", count, 3);
    for (int k = 1; k <= 7; k++) begin
      tick;
      chk("t3_count", count, (k % 3 == 0) ? 3 : 3 - (k % 3));
      chk("t3_done", done, (k % 3 == 0) ? 1 : 0);
      chk("t3_busy", busy, 1);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("t3_stop_busy", busy, 0);
    chk("t3_stop_count", count, 2);
    tick;
    chk("t3_frozen", count, 2);
    auto_reload = 1'b0;
    // pause for 4 cycles at count 4
    do_load(4'd6);
    do_start;
    tick;
    chk("t4_c5", count, 5);
    tick;
    chk("t4_c4", count, 4);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t4_hold", count, 4);
      chk("t4_busy", busy, 1);
      chk("t4_nodone", done, 0);
    end
    pause = 1'b0;
    tick;
    chk("t4_resume_hold", count, 4);
    for (int i = 3; i >= 1; i--) begin
      tick;
      chk("t4_count", count, i);
      chk("t4_nodone2", done, 0);
    end
    tick;
    chk("t4_exp_count", count, 0);
    chk("t4_exp_done", done, 1);
    // zero load, start in RUN ignored, load during RUN
    do_load(4'd0);
    do_start;
    chk("t5_zero_done", done, 1);
    chk("t5_zero_busy", busy, 0);
    tick;
    chk("t5_zero_done_off", done, 0);
    chk("t5_zero_busy2", busy, 0);
    do_load(4'd4);
    do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t5_start_ignored", count, 3);
    tick;
    chk("t5_still_run", count, 2);
    chk("t5_busy", busy, 1);
    load = 1'b1;
    load_val = 4'd9;
    start = 1'b1;
    tick;
    load = 1'b0;
    start = 1'b0;
    chk("t5_reload_count", count, 9);
    chk("t5_reload_busy", busy, 0);
    chk("t5_reload_done", done, 0);
    // async reset mid-run at count 3
    do_load(4'd5);
    do_start;
    tick;
    tick;
    chk("t1_pre_count", count, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_async_count", count, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    tick;
    tick;
    chk("t1_after_busy", busy, 0);
    chk("t1_after_count", count, 0);
    chk("t1_after_done", done, 0);
    // full-scale period of 15
    do_load(4'd15);
    do_start;
    n = 0;
    while (n < 40) begin
      tick;
      n++;
      if (done) break;
      chk("t6_noF", count, 15 - n);
    end
    chk("t6_latency", n, 15);
    chk("t6_exp_count", count, 0);
    chk("t6_exp_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
